// File: rtl/tbf_pkg.sv
// Shared encodings for the temporal block filter: requested modes, FSM states
// and the block-address width helper.
package tbf_pkg;

   localparam logic [1:0] MODE_BYPASS  = 2'd0;
   localparam logic [1:0] MODE_AVG     = 2'd1;
   localparam logic [1:0] MODE_FREEZE  = 2'd2;
   localparam logic [1:0] MODE_REPRIME = 2'd3;

   typedef enum logic [1:0] {
      ST_BYPASS = 2'd0,
      ST_PRIME  = 2'd1,
      ST_AVG    = 2'd2,
      ST_FREEZE = 2'd3
   } tbfState_e;

   // Each block coordinate keeps 10-BLK bits, so the address grows as blocks shrink.
   function automatic int addrWidth(input int blk);
      return 2 * (10 - blk);
   endfunction

endpackage

// File: rtl/iir_channel.sv
// One colour channel of the first-order IIR: result = prev + ((in - prev) >>> ALPHA).
module iir_channel #(
   parameter int CW    = 5,
   parameter int ALPHA = 1
) (
   input  logic [CW-1:0] prevVal,
   input  logic [CW-1:0] newVal,
   output logic [CW-1:0] result
);

   logic signed [CW:0] diff;
   logic signed [CW:0] step;
   logic        [CW:0] sum;
   logic               unusedCarry;

   // The result always lands in [0, 2^CW-1], so the top bit of the sum is never needed.
   always_comb begin
      diff   = $signed({1'b0, newVal}) - $signed({1'b0, prevVal});
      step   = diff >>> ALPHA;
      sum    = {1'b0, prevVal} + step;
      result = sum[CW-1:0];
   end

   assign unusedCarry = sum[CW];

endmodule

// File: rtl/temporal_block_filter.sv
// Temporal block filter between camera and VGA: keeps a decimated history frame
// in external SRAM and blends, primes, freezes or bypasses it per frame.
module temporal_block_filter
   import tbf_pkg::*;
#(
   parameter int CW    = 5,
   parameter int BLK   = 1,
   parameter int ALPHA = 1
) (
   input  logic            iCLK,
   input  logic            iRST_N,
   input  logic            iVGA_BLANK,
   input  logic [9:0]      iVGA_X,
   input  logic [9:0]      iVGA_Y,
   input  logic [3*CW-1:0] iPIX,
   input  logic [1:0]      iMODE,
   output logic [3*CW-1:0] oPIX,
   output logic            oSRAM_WE_N,
   output logic [17:0]     oSRAM_ADDR,
   inout  wire  [15:0]     SRAM_DQ,
   output logic [1:0]      oSTATE
);

   localparam int PW = 3 * CW;
   localparam int AW = addrWidth(BLK);

   tbfState_e      state;
   tbfState_e      nextState;
   tbfState_e      effState;
   logic           primePending;
   logic [PW-1:0]  blkReg;
   logic [PW-1:0]  loadVal;
   logic [PW-1:0]  avgVal;
   logic [BLK-1:0] ph;
   logic           readCyc;
   logic           writeCyc;
   logic           frameStart;
   logic           weN;
   logic [AW-1:0]  blockAddr;
   logic [15:0]    dqOut;
   logic           unusedDqBits;

   assign ph         = iVGA_X[BLK-1:0];
   assign readCyc    = (ph == '0);
   assign writeCyc   = &ph;
   assign frameStart = (iVGA_X == 10'd0) && (iVGA_Y == 10'd0);
   assign blockAddr  = {iVGA_Y[9:BLK], iVGA_X[9:BLK]};

   always_comb begin
      oSRAM_ADDR           = '0;
      oSRAM_ADDR[AW-1:0]   = blockAddr;
      dqOut                = '0;
      dqOut[PW-1:0]        = blkReg;
   end

   for (genvar c = 0; c < 3; c++) begin : gChan
      iir_channel #(.CW(CW), .ALPHA(ALPHA)) uIir (
         .prevVal (SRAM_DQ[c*CW +: CW]),
         .newVal  (iPIX[c*CW +: CW]),
         .result  (avgVal[c*CW +: CW])
      );
   end

   // Averaging is only reachable from a PRIME that has covered one whole frame;
   // the frame-start pixel itself is already processed in the newly chosen mode.
   always_comb begin
      case (iMODE)
         MODE_BYPASS:  nextState = ST_BYPASS;
         MODE_FREEZE:  nextState = ST_FREEZE;
         MODE_REPRIME: nextState = ST_PRIME;
         default:      nextState = (state == ST_BYPASS || (state == ST_PRIME && primePending))
                                   ? ST_PRIME : ST_AVG;
      endcase
      effState = frameStart ? nextState : state;
   end

   always_comb begin
      case (effState)
         ST_AVG:    loadVal = avgVal;
         ST_PRIME:  loadVal = iPIX;
         ST_FREEZE: loadVal = SRAM_DQ[PW-1:0];
         default:   loadVal = blkReg;
      endcase
   end

   always_ff @(posedge iCLK) begin
      if (!iRST_N) begin
         state        <= ST_PRIME;
         primePending <= 1'b1;
         blkReg       <= '0;
         oPIX         <= '0;
      end else begin
         if (frameStart) begin
            state        <= nextState;
            primePending <= 1'b0;
         end
         if (readCyc)
            blkReg <= loadVal;
         if (effState == ST_BYPASS)
            oPIX <= iPIX;
         else if (readCyc)
            oPIX <= loadVal;
         else
            oPIX <= blkReg;
      end
   end

   assign weN = !(iRST_N && iVGA_BLANK && writeCyc && (state == ST_PRIME || state == ST_AVG));

   assign oSRAM_WE_N   = weN;
   assign SRAM_DQ      = weN ? 16'bz : dqOut;
   assign oSTATE       = state;
   assign unusedDqBits = ^SRAM_DQ;

endmodule

// File: tb/tb_temporal_block_filter.sv
// Randomised bench for temporal_block_filter on a shrunken raster, with an
// asynchronous SRAM model and a frame-level reference of the filter.
module tb_temporal_block_filter;

   localparam int CW    = 5;
   localparam int BLK   = 1;
   localparam int ALPHA = 1;
   localparam int PW    = 3 * CW;
   localparam int B     = 1 << BLK;
   localparam int COLS  = 24;
   localparam int ROWS  = 10;
   localparam int VIS_W = 16;
   localparam int VIS_H = 8;

   localparam int K_BYPASS = 0;
   localparam int K_PRIME  = 1;
   localparam int K_AVG    = 2;
   localparam int K_FREEZE = 3;

   logic          iCLK = 1'b0;
   logic          iRST_N;
   logic          iVGA_BLANK;
   logic [9:0]    iVGA_X;
   logic [9:0]    iVGA_Y;
   logic [PW-1:0] iPIX;
   logic [1:0]    iMODE;
   logic [PW-1:0] oPIX;
   logic          oSRAM_WE_N;
   logic [17:0]   oSRAM_ADDR;
   wire  [15:0]   SRAM_DQ;
   logic [1:0]    oSTATE;

   logic [15:0]   physMem [0:4095];
   logic [15:0]   refMem  [0:4095];
   logic          sramOe;

   int            errors = 0;
   int            checks = 0;
   int            curX = 0;
   int            curY = 0;
   int            mState = K_PRIME;
   bit            mPending = 1'b1;
   logic [PW-1:0] mBlk = '0;
   logic [PW-1:0] expOpix = '0;
   bit            expValid = 1'b0;

   temporal_block_filter #(.CW(CW), .BLK(BLK), .ALPHA(ALPHA)) dut (
      .iCLK       (iCLK),
      .iRST_N     (iRST_N),
      .iVGA_BLANK (iVGA_BLANK),
      .iVGA_X     (iVGA_X),
      .iVGA_Y     (iVGA_Y),
      .iPIX       (iPIX),
      .iMODE      (iMODE),
      .oPIX       (oPIX),
      .oSRAM_WE_N (oSRAM_WE_N),
      .oSRAM_ADDR (oSRAM_ADDR),
      .SRAM_DQ    (SRAM_DQ),
      .oSTATE     (oSTATE)
   );

   always #5 iCLK = ~iCLK;

   // The SRAM answers on read-phase cycles only, so the DUT's bus is otherwise free.
   assign sramOe  = oSRAM_WE_N && iRST_N && (iVGA_X[BLK-1:0] == '0);
   assign SRAM_DQ = sramOe ? physMem[oSRAM_ADDR[11:0]] : 16'bz;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (x=%0d y=%0d)", tag, got, exp, curX, curY);
      end
   endtask

   function automatic logic [PW-1:0] iirRef(input logic [PW-1:0] prev, input logic [PW-1:0] cur);
      logic [PW-1:0] r;
      int p, n, d, q, den;
      r   = '0;
      den = 1 << ALPHA;
      for (int c = 0; c < 3; c++) begin
         p = int'(prev[c*CW +: CW]);
         n = int'(cur[c*CW +: CW]);
         d = n - p;
         q = (d >= 0) ? d / den : -((-d + den - 1) / den);
         r[c*CW +: CW] = CW'(p + q);
      end
      return r;
   endfunction

   function automatic int nextKind(input int cur, input bit pending, input logic [1:0] mode);
      case (mode)
         2'd0:    return K_BYPASS;
         2'd2:    return K_FREEZE;
         2'd3:    return K_PRIME;
         default: return (cur == K_BYPASS || (cur == K_PRIME && pending)) ? K_PRIME : K_AVG;
      endcase
   endfunction

   task automatic stepCycle(input bit rstN, input bit blank, input int x, input int y,
                            input logic [PW-1:0] pix, input logic [1:0] mode);
      bit            weExp;
      bit            rd;
      int            addrExp;
      int            idx;
      int            eff;
      logic [PW-1:0] loadVal;
      @(negedge iCLK);
      iRST_N     = rstN;
      iVGA_BLANK = blank;
      iVGA_X     = 10'(x);
      iVGA_Y     = 10'(y);
      iPIX       = pix;
      iMODE      = mode;
      curX       = x;
      curY       = y;
      #1;
      if (expValid) begin
         checkOutput("opix", 32'(oPIX), 32'(expOpix));
         checkOutput("state", 32'(oSTATE), 32'(mState));
      end
      addrExp = ((y >> BLK) << (10 - BLK)) | (x >> BLK);
      idx     = addrExp & 4095;
      weExp   = rstN && blank && ((x % B) == B - 1) && (mState == K_PRIME || mState == K_AVG);
      checkOutput("we_n", 32'(oSRAM_WE_N), 32'(!weExp));
      checkOutput("addr", 32'(oSRAM_ADDR), 32'(addrExp));
      if (!oSRAM_WE_N)
         physMem[oSRAM_ADDR[11:0]] = SRAM_DQ;
      if (weExp) begin
         checkOutput("dq", 32'(SRAM_DQ), 32'({1'b0, mBlk}));
         refMem[idx] = {1'b0, mBlk};
      end
      if (!rstN) begin
         mState   = K_PRIME;
         mPending = 1'b1;
         mBlk     = '0;
         expOpix  = '0;
      end else begin
         eff = mState;
         if (x == 0 && y == 0) begin
            mState   = nextKind(mState, mPending, mode);
            mPending = 1'b0;
            eff      = mState;
         end
         rd = (x % B) == 0;
         case (eff)
            K_AVG:    loadVal = iirRef(refMem[idx][PW-1:0], pix);
            K_PRIME:  loadVal = pix;
            K_FREEZE: loadVal = refMem[idx][PW-1:0];
            default:  loadVal = mBlk;
         endcase
         if (eff == K_BYPASS)
            expOpix = pix;
         else if (rd) begin
            expOpix = loadVal;
            mBlk    = loadVal;
         end else
            expOpix = mBlk;
      end
      expValid = 1'b1;
   endtask

   task automatic applyStimulus(input logic [1:0] modeA, input logic [1:0] modeB,
                                input int swX, input int swY, input bit randPix,
                                input logic [PW-1:0] pixConst, input bit randBlank,
                                input int rstX, input int rstY, input int spotExp);
      logic [1:0]    mode;
      logic [PW-1:0] pix;
      bit            blank;
      bit            rstN;
      for (int y = 0; y < ROWS; y++) begin
         for (int x = 0; x < COLS; x++) begin
            mode  = (swX >= 0 && (y > swY || (y == swY && x >= swX))) ? modeB : modeA;
            pix   = randPix ? PW'($urandom) : pixConst;
            blank = (x < VIS_W) && (y < VIS_H) && (!randBlank || $urandom_range(0, 1) == 1);
            rstN  = !(x == rstX && y == rstY);
            stepCycle(rstN, blank, x, y, pix, mode);
            if (spotExp >= 0 && x == 3 && y == 0)
               checkOutput("spot", 32'(oPIX), spotExp);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) begin
         physMem[i] = 16'($urandom);
         refMem[i]  = physMem[i];
      end
      iRST_N     = 1'b0;
      iVGA_BLANK = 1'b0;
      iVGA_X     = '0;
      iVGA_Y     = '0;
      iPIX       = '0;
      iMODE      = 2'd1;

      for (int i = 0; i < 3; i++)
         stepCycle(1'b0, 1'b1, 5 + i, 3, PW'($urandom), 2'd1);

      // Prime with 10s, then probe the address at the far corner of a 640x480 raster.
      applyStimulus(2'd1, 2'd1, -1, -1, 1'b0, 15'h294A, 1'b0, -1, -1, -1);
      stepCycle(1'b1, 1'b1, 639, 479, 15'h294A, 2'd1);
      checkOutput("addr639", 32'(oSRAM_ADDR), 32'd122687);
      checkOutput("prime_word", 32'(physMem[513]), 32'h294A);

      applyStimulus(2'd1, 2'd1, -1, -1, 1'b0, 15'h5294, 1'b0, -1, -1, 32'h3DEF);
      applyStimulus(2'd3, 2'd3, -1, -1, 1'b0, 15'h5294, 1'b0, -1, -1, -1);
      applyStimulus(2'd1, 2'd1, -1, -1, 1'b0, 15'h2D6B, 1'b0, -1, -1, 32'h3DEF);
      applyStimulus(2'd2, 2'd2, -1, -1, 1'b1, '0, 1'b0, -1, -1, -1);
      applyStimulus(2'd1, 2'd0, 10, 5, 1'b1, '0, 1'b1, -1, -1, -1);
      applyStimulus(2'd0, 2'd0, -1, -1, 1'b1, '0, 1'b0, -1, -1, -1);
      applyStimulus(2'd1, 2'd1, -1, -1, 1'b1, '0, 1'b0, -1, -1, -1);
      applyStimulus(2'd1, 2'd1, -1, -1, 1'b1, '0, 1'b0, 7, 3, -1);
      applyStimulus(2'd1, 2'd1, -1, -1, 1'b1, '0, 1'b0, -1, -1, -1);
      applyStimulus(2'd1, 2'd1, -1, -1, 1'b1, '0, 1'b1, -1, -1, -1);
      stepCycle(1'b1, 1'b0, 0, 0, PW'($urandom), 2'd2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
